// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one binary-to-BCD converter between two requesters,
// with a WAIT watchdog. Optional clamp of operands > 99: define BCD_CLAMP_99_EN.
module bcd_conv_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 32,
  parameter int unsigned CNT_W          = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [6:0] bin0,
  input  logic       req1,
  input  logic [6:0] bin1,
  output logic       ack0,
  output logic       ack1,
  output logic [3:0] res_tens,
  output logic [3:0] res_units,
  output logic       res_err,
  output logic       res_ovf,
  output logic       conv_start,
  output logic [6:0] conv_bin,
  input  logic       conv_done,
  input  logic [3:0] conv_bcd_tens,
  input  logic [3:0] conv_bcd_units,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DELIVER} state_e;

  state_e           state_q, state_d;
  logic [6:0]       conv_bin_q, conv_bin_d;
  logic             grant_q, grant_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic [3:0]       res_tens_q, res_tens_d;
  logic [3:0]       res_units_q, res_units_d;
  logic             res_err_q, res_err_d;
`ifdef BCD_CLAMP_99_EN
  logic             res_ovf_q, res_ovf_d;
`endif

  logic             pick;
  logic [6:0]       pick_bin;

  always_comb begin
    // prio_q names the favoured channel on a tie; it flips to the other channel after each delivery
    pick        = (req0 && req1) ? prio_q : req1;
    pick_bin    = pick ? bin1 : bin0;
    state_d     = state_q;
    conv_bin_d  = conv_bin_q;
    grant_d     = grant_q;
    prio_d      = prio_q;
    wdog_d      = wdog_q;
    res_tens_d  = res_tens_q;
    res_units_d = res_units_q;
    res_err_d   = res_err_q;
`ifdef BCD_CLAMP_99_EN
    res_ovf_d   = res_ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          grant_d = pick;
`ifdef BCD_CLAMP_99_EN
          if (pick_bin > 7'd99) begin
            res_tens_d  = 4'd9;
            res_units_d = 4'd9;
            res_err_d   = 1'b0;
            res_ovf_d   = 1'b1;
            state_d     = S_DELIVER;
          end else begin
            conv_bin_d = pick_bin;
            state_d    = S_LAUNCH;
          end
`else
          conv_bin_d = pick_bin;
          state_d    = S_LAUNCH;
`endif
        end
      end
      S_LAUNCH: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (conv_done) begin
          res_tens_d  = conv_bcd_tens;
          res_units_d = conv_bcd_units;
          res_err_d   = 1'b0;
`ifdef BCD_CLAMP_99_EN
          res_ovf_d   = 1'b0;
`endif
          state_d     = S_DELIVER;
        end else if (wdog_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          res_tens_d  = 4'hF;
          res_units_d = 4'hF;
          res_err_d   = 1'b1;
`ifdef BCD_CLAMP_99_EN
          res_ovf_d   = 1'b0;
`endif
          state_d     = S_DELIVER;
        end else begin
          wdog_d = wdog_q + CNT_W'(1);
        end
      end
      S_DELIVER: begin
        prio_d  = ~grant_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      conv_bin_q  <= '0;
      grant_q     <= 1'b0;
      prio_q      <= 1'b0;
      wdog_q      <= '0;
      res_tens_q  <= '0;
      res_units_q <= '0;
      res_err_q   <= 1'b0;
`ifdef BCD_CLAMP_99_EN
      res_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      conv_bin_q  <= conv_bin_d;
      grant_q     <= grant_d;
      prio_q      <= prio_d;
      wdog_q      <= wdog_d;
      res_tens_q  <= res_tens_d;
      res_units_q <= res_units_d;
      res_err_q   <= res_err_d;
`ifdef BCD_CLAMP_99_EN
      res_ovf_q   <= res_ovf_d;
`endif
    end
  end

  // A requester that dropped req before DELIVER gets no ack; its result is discarded
  assign ack0       = (state_q == S_DELIVER) && !grant_q && req0;
  assign ack1       = (state_q == S_DELIVER) &&  grant_q && req1;
  assign conv_start = (state_q == S_LAUNCH);
  assign busy       = (state_q != S_IDLE);
  assign conv_bin   = conv_bin_q;
  assign res_tens   = res_tens_q;
  assign res_units  = res_units_q;
  assign res_err    = res_err_q;
`ifdef BCD_CLAMP_99_EN
  assign res_ovf    = res_ovf_q;
`else
  assign res_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter: converter model, directed cases, randomized rounds.
module tb_bcd_conv_arbiter;
  localparam int TO = 32;

  logic clk = 1'b0;
  logic reset, req0, req1, conv_done, model_done, stray_done;
  logic [6:0] bin0, bin1, conv_bin;
  logic ack0, ack1, res_err, res_ovf, conv_start, busy;
  logic [3:0] res_tens, res_units, conv_bcd_tens, conv_bcd_units;

  always #5 clk = ~clk;

  bcd_conv_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .req0(req0), .bin0(bin0), .req1(req1), .bin1(bin1),
    .ack0(ack0), .ack1(ack1), .res_tens(res_tens), .res_units(res_units),
    .res_err(res_err), .res_ovf(res_ovf), .conv_start(conv_start), .conv_bin(conv_bin),
    .conv_done(conv_done), .conv_bcd_tens(conv_bcd_tens), .conv_bcd_units(conv_bcd_units),
    .busy(busy)
  );

  assign conv_done = model_done | stray_done;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Converter model: answers conv_lat cycles after a start; conv_lat == 0 never answers
  int   conv_lat;
  bit   m_pend = 1'b0;
  int   m_cnt = 0;
  always @(negedge clk) begin
    model_done <= 1'b0;
    if (reset) m_pend <= 1'b0;
    else if (m_pend) begin
      if (m_cnt == 1) begin model_done <= 1'b1; m_pend <= 1'b0; end
      m_cnt <= m_cnt - 1;
    end
    if (conv_start && !reset && conv_lat != 0) begin
      m_pend         <= 1'b1;
      m_cnt          <= conv_lat;
      conv_bcd_tens  <= 4'(conv_bin / 7'd10);
      conv_bcd_units <= 4'(conv_bin % 7'd10);
    end
  end

  int ack0_cnt = 0, ack1_cnt = 0, overlap_cnt = 0, start_cnt = 0;
  bit outstanding = 1'b0;
  always @(negedge clk) begin
    if (ack0) ack0_cnt <= ack0_cnt + 1;
    if (ack1) ack1_cnt <= ack1_cnt + 1;
    if (conv_start) start_cnt <= start_cnt + 1;
    if (conv_start && outstanding) overlap_cnt <= overlap_cnt + 1;
    if (reset || !busy) outstanding <= 1'b0;
    else if (conv_start) outstanding <= 1'b1;
  end

  int checks = 0, errors = 0;
  int last_srv;

  task automatic chk(input string tag, input bit pass);
    checks++;
    if (!pass) begin
      errors++;
      $error("FAIL %s", tag);
    end
  endtask

  function automatic logic [9:0] ref_res(input int b, input bit timed_out);
    if (timed_out) return {4'hF, 4'hF, 1'b1, 1'b0};
`ifdef BCD_CLAMP_99_EN
    if (b > 99) return {4'd9, 4'd9, 1'b0, 1'b1};
`endif
    return {4'(b / 10), 4'(b % 10), 1'b0, 1'b0};
  endfunction

  function automatic int ref_grant(input logic r0, input logic r1);
    if (r0 && r1) return (last_srv == 0) ? 1 : 0;
    return r1 ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int maxc, output int scyc, output bit ok);
    ok = 1'b0; scyc = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (conv_start) begin ok = 1'b1; scyc = cyc; break; end
    end
  endtask

  task automatic wait_ack(input int maxc, output int acyc, output int ch,
                          output logic [9:0] res, output bit ok);
    ok = 1'b0; acyc = -1; ch = -1; res = '0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        ok = 1'b1; acyc = cyc; ch = ack1 ? 1 : 0;
        res = {res_tens, res_units, res_err, res_ovf};
        break;
      end
    end
  endtask

  // Serve n grants; hold=1 keeps both requests up throughout, else the served channel drops req
  task automatic serve(input int n, input bit hold);
    int exp_ch, exp_b, acyc, ch;
    logic [9:0] res;
    bit ok;
    for (int k = 0; k < n; k++) begin
      exp_ch = ref_grant(req0, req1);
      exp_b  = (exp_ch == 1) ? int'(bin1) : int'(bin0);
      wait_ack(80, acyc, ch, res, ok);
      chk("ack_seen", ok === 1'b1);
      if (!ok) return;
      chk("grant_ch", ch === exp_ch);
      chk("result", res === ref_res(exp_b, 1'b0));
      last_srv = exp_ch;
      tick();
      if (!hold) begin
        if (exp_ch == 0) req0 = 1'b0; else req1 = 1'b0;
      end
    end
    if (hold) begin req0 = 1'b0; req1 = 1'b0; end
  endtask

  int s, a, c0, ch, a0, a1, st0;
  bit ok;
  logic [9:0] res;
  int r;

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; bin0 = '0; bin1 = '0;
    stray_done = 1'b0; conv_lat = 5; last_srv = 1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ctrl", {ack0, ack1, conv_start, busy, res_err, res_ovf} === 6'b0);
    chk("rst_data", {res_tens, res_units, conv_bin} === 15'b0);

    // Single ch0 request, bin changed after grant
    tick();
    c0 = cyc; req0 = 1'b1; bin0 = 7'd37;
    wait_start(5, s, ok);
    chk("t1_start_seen", ok === 1'b1);
    chk("t1_start_lat", (s - c0) === 1);
    chk("t1_conv_bin", conv_bin === 7'd37);
    tick();
    bin0 = 7'd99;
    wait_ack(20, a, ch, res, ok);
    chk("t1_ack_seen", ok === 1'b1);
    chk("t1_ack_lat", (a - s) === (conv_lat + 1));
    chk("t1_ch", ch === 0);
    chk("t1_res", res === ref_res(37, 1'b0));
    last_srv = 0;
    tick();
    req0 = 1'b0;
    tick(); tick();
    chk("t1_ack0_once", ack0_cnt === 1);
    chk("t1_no_ack1", ack1_cnt === 0);

    // Both held: alternating grants from a fresh reset
    reset = 1'b1; tick(); reset = 1'b0; last_srv = 1;
    req0 = 1'b1; bin0 = 7'd12; req1 = 1'b1; bin1 = 7'd85;
    serve(4, 1'b1);
    chk("t2_no_overlap", overlap_cnt === 0);

    // Converter never answers: watchdog completion, then a stray late done
    conv_lat = 0;
    tick();
    req0 = 1'b1; bin0 = 7'd50;
    wait_start(5, s, ok);
    chk("t3_start_seen", ok === 1'b1);
    wait_ack(45, a, ch, res, ok);
    chk("t3_ack_seen", ok === 1'b1);
    chk("t3_ack_lat", (a - s) === (TO + 1));
    chk("t3_res", res === ref_res(50, 1'b1));
    last_srv = 0;
    tick();
    req0 = 1'b0;
    a0 = ack0_cnt; a1 = ack1_cnt;
    stray_done = 1'b1; tick(); stray_done = 1'b0;
    repeat (3) tick();
    chk("t3_late_no_ack", (ack0_cnt + ack1_cnt) === (a0 + a1));
    chk("t3_res_held", {res_tens, res_units, res_err} === 9'h1FF);
    chk("t3_idle", busy === 1'b0);
    conv_lat = 20;

    // Reset during WAIT
    req1 = 1'b1; bin1 = 7'd44;
    wait_start(5, s, ok);
    chk("t4_start_seen", ok === 1'b1);
    repeat (3) tick();
    reset = 1'b1; req1 = 1'b0;
    tick();
    reset = 1'b0; last_srv = 1;
    chk("t4_rst_outputs", {ack0, ack1, conv_start, busy, res_err, res_ovf, res_tens, res_units, conv_bin} === 21'b0);
    a0 = ack0_cnt; a1 = ack1_cnt;
    stray_done = 1'b1; tick(); stray_done = 1'b0;
    tick(); tick();
    chk("t4_stray_no_ack", (ack0_cnt + ack1_cnt) === (a0 + a1));
    chk("t4_idle", busy === 1'b0);
    conv_lat = 5;
    req0 = 1'b1; bin0 = 7'd9; req1 = 1'b1; bin1 = 7'd66;
    serve(2, 1'b0);

    // Requester drops during WAIT: no ack, pointer still advances
    req0 = 1'b1; bin0 = 7'd71;
    serve(1, 1'b0);
    req1 = 1'b1; bin1 = 7'd23;
    wait_start(5, s, ok);
    chk("t5_start_seen", ok === 1'b1);
    tick(); tick();
    req1 = 1'b0;
    a1 = ack1_cnt;
    repeat (10) tick();
    chk("t5_no_ack1", ack1_cnt === a1);
    chk("t5_idle", busy === 1'b0);
    last_srv = 1;
    req0 = 1'b1; bin0 = 7'd5; req1 = 1'b1; bin1 = 7'd58;
    serve(2, 1'b0);

    // Operand above 99
    c0 = cyc; st0 = start_cnt;
    req0 = 1'b1; bin0 = 7'd120;
`ifdef BCD_CLAMP_99_EN
    wait_ack(10, a, ch, res, ok);
    chk("t6_ack_seen", ok === 1'b1);
    chk("t6_ack_lat", (a - c0) === 1);
    chk("t6_no_start", start_cnt === st0);
`else
    wait_start(5, s, ok);
    chk("t6_start_seen", ok === 1'b1);
    chk("t6_conv_bin", conv_bin === 7'd120);
    wait_ack(20, a, ch, res, ok);
    chk("t6_ack_seen", ok === 1'b1);
`endif
    chk("t6_ch", ch === 0);
    chk("t6_res", res === ref_res(120, 1'b0));
    last_srv = 0;
    tick();
    req0 = 1'b0;

    // Randomized rounds
    for (int i = 0; i < 25; i++) begin
      tick();
      r = int'($urandom_range(1, 3));
      req0 = r[0]; req1 = r[1];
      bin0 = 7'($urandom_range(0, 127));
      bin1 = 7'($urandom_range(0, 127));
      conv_lat = int'($urandom_range(1, 8));
      serve((r == 3) ? 2 : 1, 1'b0);
    end
    chk("end_no_overlap", overlap_cnt === 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=stuck expected=finish");
    $fatal(1);
  end

endmodule
